// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader sitting in front of the CPU core.
//
// Receives a byte stream over a valid/ready handshake. The stream starts with a
// 16-bit little-endian word count, followed by the payload bytes. Each group of
// four payload bytes is assembled into a little-endian 32-bit instruction and
// written to instruction memory through the CPU external port. When the whole
// program has been written, cpu_enable is held high.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a running XOR of every accepted header and payload byte is
//   kept. After the last write, one trailer byte is accepted and compared with
//   that XOR. A match finishes the load; a mismatch aborts it with error set.
//
// Parameters:
//   ADDR_W     instruction memory word-address width (max 2^ADDR_W words)
//   BASE_ADDR  byte address of the first word written
//   ADDR_STEP  byte-address increment between consecutive words
//
// Ports:
//   clk           system clock
//   arst          asynchronous active-high reset
//   start         one-cycle pulse that begins a load (honoured in IDLE/DONE/ERROR)
//   s_data        stream byte
//   s_valid       s_data is valid this cycle
//   s_ready       loader accepts s_data this cycle
//   addr_ext      instruction memory byte address (valid while wen_ext is high)
//   wen_ext       instruction memory write strobe
//   wdata_ext     instruction word to write
//   cpu_enable    CPU enable, high after a successful load
//   busy          a load is in progress
//   done          load completed successfully (sticky until next start)
//   error         load aborted (sticky until next start)
//   words_loaded  number of words written in the current load
module imem_loader #(
  parameter int unsigned ADDR_W    = 9,
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter logic [63:0] ADDR_STEP = 64'd4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [63:0]       addr_ext,
  output logic              wen_ext,
  output logic [31:0]       wdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    S_CHECK
`endif
  } state_t;

  // Largest legal word count; widened so 2^ADDR_W itself is representable.
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

  state_t            state;
  state_t            state_nxt;

  logic [15:0]       count;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [ADDR_W:0]   word_idx;
  logic [63:0]       addr_q;
  logic [31:0]       wdata_q;

  logic              take;
  logic [15:0]       hdr_count;
  logic              count_too_big;
  logic              last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign take          = s_valid && s_ready;
  // Full count as it will be once the high header byte is latched.
  assign hdr_count     = {s_data, count[7:0]};
  assign count_too_big = 33'(hdr_count) > MAX_WORDS;
  // Evaluated in WRITE: is the word index after this write equal to count?
  assign last_word     = (33'(word_idx) + 33'd1) == 33'(count);

  assign addr_ext      = addr_q;
  assign wdata_ext     = wdata_q;
  assign words_loaded  = word_idx;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Status outputs are decoded straight from the state register so an
  // asynchronous reset clears them (wen_ext included) without waiting for a clock.
  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    wen_ext    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_enable = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LEN_LO;
      end

      S_LEN_LO: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (take) state_nxt = S_LEN_HI;
      end

      S_LEN_HI: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (take) begin
          if (hdr_count == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = S_CHECK;
`else
            state_nxt = S_DONE;
`endif
          end else if (count_too_big) begin
            state_nxt = S_ERROR;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (take && byte_idx == 2'd3) state_nxt = S_WRITE;
      end

      S_WRITE: begin
        wen_ext = 1'b1;
        busy    = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_PAYLOAD;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (take) state_nxt = (s_data == csum) ? S_DONE : S_ERROR;
      end
`endif

      S_DONE: begin
        done       = 1'b1;
        cpu_enable = 1'b1;
        if (start) state_nxt = S_LEN_LO;
      end

      S_ERROR: begin
        error = 1'b1;
        if (start) state_nxt = S_LEN_LO;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: header capture, word assembly, write address/data and counters.
  // addr_q/wdata_q are loaded on the edge that accepts the last byte of a word,
  // so they are valid throughout WRITE and hold afterwards.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count    <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      word_idx <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            count    <= '0;
            byte_idx <= '0;
            word_idx <= '0;
          end
        end

        S_LEN_LO: begin
          if (take) count[7:0] <= s_data;
        end

        S_LEN_HI: begin
          if (take) count[15:8] <= s_data;
        end

        S_PAYLOAD: begin
          if (take) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= s_data;
              2'd1: word_buf[15:8]  <= s_data;
              2'd2: word_buf[23:16] <= s_data;
              default: begin
                wdata_q <= {s_data, word_buf};
                addr_q  <= BASE_ADDR + ADDR_STEP * 64'(word_idx);
              end
            endcase
          end
        end

        S_WRITE: begin
          word_idx <= word_idx + 1'b1;
        end

        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over header and payload bytes; the trailer byte is excluded.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      csum <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) csum <= '0;
        end
        S_LEN_LO, S_LEN_HI, S_PAYLOAD: begin
          if (take) csum <= csum ^ s_data;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Testbench for imem_loader: randomized and directed loads checked against a
// stream-level reference model (header count, payload words, expected writes).
module tb_imem_loader;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  logic              clk;
  logic              arst;
  logic              start;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [63:0]       addr_ext;
  logic              wen_ext;
  logic [31:0]       wdata_ext;
  logic              cpu_enable;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (64'd0),
    .ADDR_STEP (64'd4)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .addr_ext     (addr_ext),
    .wen_ext      (wen_ext),
    .wdata_ext    (wdata_ext),
    .cpu_enable   (cpu_enable),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned cyc     = 0;
  int unsigned viol    = 0;

  // Observed writes.
  logic [63:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int unsigned wr_cyc_q[$];

  // Reference model inputs and outputs.
  logic [31:0] pay[$];
  logic [7:0]  stream[$];
  logic [63:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done;
  bit          exp_err;
  int unsigned exp_words;

  always @(negedge clk) begin
    cyc++;
    if (wen_ext) begin
      wr_addr_q.push_back(addr_ext);
      wr_data_q.push_back(wdata_ext);
      wr_cyc_q.push_back(cyc);
    end
    // While loading, the loader only withholds ready during the write cycle.
    if ((busy && !wen_ext && !s_ready) || (wen_ext && s_ready)) viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  // Offer one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bit sent;
    sent    = 1'b0;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_data  = b;
    s_valid = 1'b1;
    for (int n = 0; n < 50 && !sent; n++) begin
      @(negedge clk);
      if (s_ready) begin
        tick();
        sent = 1'b1;
      end
    end
    s_valid = 1'b0;
    if (!sent) check("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_range(input int first, input int last, input int unsigned gap, input bit rnd);
    for (int i = first; i <= last; i++)
      send_byte(stream[i], rnd ? $urandom_range(0, gap) : gap);
  endtask

  // Build the byte stream for 'cnt' words taken from pay[] and the expected
  // outcome: writes at 4*i, LE byte order, length limit and optional trailer.
  task automatic make_case(input int unsigned cnt, input bit bad_sum);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    stream.delete();
    exp_addr.delete();
    exp_data.delete();
    stream.push_back(cnt[7:0]);
    stream.push_back(cnt[15:8]);
    x         = cnt[7:0] ^ cnt[15:8];
    exp_words = 0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    if (cnt > MAX_WORDS) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(cnt); i++) begin
        w = pay[i];
        exp_addr.push_back(64'(i) * 64'd4);
        exp_data.push_back(w);
        for (int k = 0; k < 4; k++) begin
          b = w[8*k +: 8];
          stream.push_back(b);
          x = x ^ b;
        end
      end
      exp_words = cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream.push_back(bad_sum ? ~x : x);
      exp_done = !bad_sum;
      exp_err  = bad_sum;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic fill_pay(input int unsigned n);
    pay.delete();
    for (int i = 0; i < int'(n); i++) pay.push_back($urandom);
  endtask

  task automatic verify(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), 64'(wr_data_q[i]), 64'(exp_data[i]));
    end
    check({tag, "_done"},  64'(done),         64'(exp_done));
    check({tag, "_error"}, 64'(error),        64'(exp_err));
    check({tag, "_cpuen"}, 64'(cpu_enable),   64'(exp_done));
    check({tag, "_busy"},  64'(busy),         64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'(exp_words));
  endtask

  task automatic run_case(input string tag, input int unsigned cnt, input bit bad,
                          input int unsigned gap, input bit rnd);
    make_case(cnt, bad);
    clear_obs();
    tick();
    pulse_start();
    send_range(0, stream.size() - 1, gap, rnd);
    verify(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(busy),         64'd0);
    check({tag, "_rdy"},   64'(s_ready),      64'd0);
    check({tag, "_wen"},   64'(wen_ext),      64'd0);
    check({tag, "_done"},  64'(done),         64'd0);
    check({tag, "_err"},   64'(error),        64'd0);
    check({tag, "_cpuen"}, 64'(cpu_enable),   64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
    check({tag, "_addr"},  addr_ext,          64'd0);
    check({tag, "_wdata"}, 64'(wdata_ext),    64'd0);
  endtask

  initial begin
    arst    = 1'b1;
    start   = 1'b0;
    s_data  = 8'h00;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    tick();
    arst = 1'b0;

    // Two-word program with s_valid held high.
    pay = {32'h00100513, 32'h00200593};
    run_case("two", 2, 1'b0, 0, 1'b0);
    check("two_w0_data", 64'(wr_data_q.size() > 0 ? wr_data_q[0] : 32'h0), 64'h00100513);
    if (wr_cyc_q.size() == 2)
      check("two_period", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd5);

    // Restart from DONE: enable drops, busy rises on the next cycle.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("restart_cpuen", 64'(cpu_enable), 64'd0);
    check("restart_busy",  64'(busy),       64'd1);
    check("restart_words", 64'(words_loaded), 64'd0);
    fill_pay(3);
    make_case(3, 1'b0);
    clear_obs();
    tick();
    send_range(0, 5, 0, 1'b0);
    tick();
    tick();
    pulse_start();
    @(negedge clk);
    check("busy_start_words", 64'(words_loaded), 64'd1);
    check("busy_start_busy",  64'(busy),         64'd1);
    tick();
    send_range(6, stream.size() - 1, 0, 1'b0);
    verify("restart");

    // Same two-word program with 3 idle cycles before every byte.
    pay = {32'h00100513, 32'h00200593};
    run_case("stall", 2, 1'b0, 3, 1'b0);

    // Oversized header: error immediately after the high length byte.
    make_case(513, 1'b0);
    clear_obs();
    tick();
    pulse_start();
    send_range(0, 1, 0, 1'b0);
    @(negedge clk);
    check("len513_err_now", 64'(error),      64'd1);
    check("len513_cpuen",   64'(cpu_enable), 64'd0);
    verify("len513");

    // Zero-length program.
    run_case("len0", 0, 1'b0, 0, 1'b0);

    // Reset after two payload bytes of word 0.
    pay = {32'h00100513, 32'h00200593};
    make_case(2, 1'b0);
    clear_obs();
    tick();
    pulse_start();
    send_range(0, 3, 0, 1'b0);
    #2;
    arst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    arst = 1'b0;
    run_case("after_rst", 2, 1'b0, 1, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay = {32'h00100513};
    run_case("csum_ok", 1, 1'b0, 0, 1'b0);
    check("csum_ok_trailer", 64'(stream[6]), 64'h07);
    make_case(1, 1'b1);
    void'(stream.pop_back());
    stream.push_back(8'h00);
    clear_obs();
    tick();
    pulse_start();
    send_range(0, stream.size() - 1, 0, 1'b0);
    verify("csum_bad");
`endif

    // Randomized loads.
    for (int t = 0; t < 10; t++) begin
      int unsigned cnt;
      cnt = $urandom_range(1, 8);
      fill_pay(cnt);
      run_case($sformatf("rnd%0d", t), cnt, ($urandom_range(0, 3) == 0), 3, 1'b1);
    end
    run_case("rnd_big", $urandom_range(MAX_WORDS + 1, 65535), 1'b0, 2, 1'b1);

    // Maximum legal length: last word lands at 4*(2^ADDR_W-1).
    fill_pay(MAX_WORDS);
    run_case("max", MAX_WORDS, 1'b0, 0, 1'b0);

    check("ready_rule", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
